// File: rtl/smac_pkg.sv
// Shared types and constants for the SMAC activation path: the serializer FSM
// states and the accumulator strobe patterns shared with the accumulator controller.
package smac_pkg;

  localparam int M_DEFAULT  = 16;
  localparam int PA_DEFAULT = 8;
  localparam int PLANE_W    = $clog2(PA_DEFAULT);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef struct packed {
    logic cl_en;
    logic w_en;
    logic s_en;
  } strobe_t;

  // Plane 0 loads the accumulator; later planes shift it with sign extension.
  localparam strobe_t STROBE_LOAD  = '{cl_en: 1'b1, w_en: 1'b1, s_en: 1'b0};
  localparam strobe_t STROBE_SHIFT = '{cl_en: 1'b0, w_en: 1'b1, s_en: 1'b1};
  localparam strobe_t STROBE_NONE  = '{cl_en: 1'b0, w_en: 1'b0, s_en: 1'b0};

endpackage

// File: rtl/act_bitplane_ser_if.sv
// Bundle between the activation buffer, the serializer and the dot-product lanes.
// slave = the serializer itself, master = the environment around it.
interface act_bitplane_ser_if #(
  parameter int M  = 16,
  parameter int Pa = 8
);
  localparam int PW = $clog2(Pa);

  logic              in_valid;
  logic              in_ready;
  logic [M*Pa-1:0]   in_act;
  logic              out_valid;
  logic              out_ready;
  logic [M-1:0]      out_plane;
  logic [PW-1:0]     plane_idx;
  logic              plane_first;
  logic              plane_last;
  logic              acc_cl_en;
  logic              acc_w_en;
  logic              acc_s_en;
  logic              acc_done;

  modport slave (
    input  in_valid, in_act, out_ready,
    output in_ready, out_valid, out_plane, plane_idx, plane_first, plane_last,
           acc_cl_en, acc_w_en, acc_s_en, acc_done
  );

  modport master (
    output in_valid, in_act, out_ready,
    input  in_ready, out_valid, out_plane, plane_idx, plane_first, plane_last,
           acc_cl_en, acc_w_en, acc_s_en, acc_done
  );

endinterface

// File: rtl/act_bitplane_ser_lane.sv
// One activation lane: Pa-bit register that loads a parallel word and shifts it
// right one bit per plane, presenting the current bit on lsb.
module act_lane_sr #(
  parameter int Pa = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          shift,
  input  logic [Pa-1:0] din,
  output logic          lsb
);

  logic [Pa-1:0] q;

  // NOTE: non-blocking assignments so every lane updates from its pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {1'b0, q[Pa-1:1]};
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/act_bitplane_ser.sv
// Bit-serial activation transmitter: takes an M x Pa vector and emits Pa bit-planes
// LSB first, with aligned accumulator clear/write/shift strobes and a done pulse.
module act_bitplane_ser
  import smac_pkg::*;
#(
  parameter int M  = M_DEFAULT,
  parameter int Pa = PA_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  act_bitplane_ser_if.slave bus
);

  localparam int            PW       = $clog2(Pa);
  localparam logic [PW-1:0] LAST_IDX = PW'(Pa - 1);

  state_t        state, state_n;
  logic [PW-1:0] cnt, cnt_n;
  logic          ready_en;
  logic          done_q;
  logic          streaming;
  logic          last;
  logic          beat;
  logic          in_xfer;
  logic          shift;
  logic [M-1:0]  lsb;
  strobe_t       strobe;

  assign streaming = (state == STREAM);
  assign last      = streaming && (cnt == LAST_IDX);
  assign beat      = streaming && bus.out_ready;

  // ready_en keeps in_ready low while rst_n is held and until the first edge after.
  assign bus.in_ready = ready_en && (!streaming || (last && bus.out_ready));
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign shift        = beat && !last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ready_en <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ready_en <= 1'b1;
      done_q   <= beat && last;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    strobe  = STROBE_NONE;
    unique case (state)
      IDLE: begin
        if (in_xfer) begin
          state_n = STREAM;
          cnt_n   = '0;
        end
      end
      STREAM: begin
        if (beat) begin
          strobe = (cnt == '0) ? STROBE_LOAD : STROBE_SHIFT;
          if (!last) begin
            cnt_n = cnt + PW'(1);
          end else if (in_xfer) begin
            cnt_n = '0;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // A reload can only happen when in_ready is high, so in_xfer alone is the load.
  for (genvar g = 0; g < M; g++) begin : g_lane
    act_lane_sr #(.Pa(Pa)) u_sr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (in_xfer),
      .shift (shift),
      .din   (bus.in_act[g*Pa +: Pa]),
      .lsb   (lsb[g])
    );
  end

  assign bus.out_valid   = streaming;
  assign bus.out_plane   = lsb;
  assign bus.plane_idx   = cnt;
  assign bus.plane_first = streaming && (cnt == '0);
  assign bus.plane_last  = last;
  assign bus.acc_cl_en   = strobe.cl_en;
  assign bus.acc_w_en    = strobe.w_en;
  assign bus.acc_s_en    = strobe.s_en;
  assign bus.acc_done    = done_q;

endmodule

// File: tb/tb_act_bitplane_ser.sv
// Bench for act_bitplane_ser: directed M=4/Pa=4 sequences plus randomized
// M=16/Pa=8 traffic reassembled against the sent vectors.
module tb_act_bitplane_ser;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  act_bitplane_ser_if #(.M(4),  .Pa(4)) ia ();
  act_bitplane_ser_if #(.M(16), .Pa(8)) ib ();

  act_bitplane_ser #(.M(4),  .Pa(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  act_bitplane_ser #(.M(16), .Pa(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       in_valid;
    logic       out_ready;
    logic       valid;
    logic [3:0] plane;
    int         idx;
    logic       ready;
    logic [2:0] stb;   // {cl, w, s}
    logic       done;
  } row_t;

  localparam logic [2:0] S_LOAD  = 3'b110;
  localparam logic [2:0] S_SHIFT = 3'b011;
  localparam logic [2:0] S_NONE  = 3'b000;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic row_t mk(input logic iv, input logic orr, input logic v, input logic [3:0] pl,
                              input int idx, input logic rdy, input logic [2:0] stb, input logic dn);
    row_t r;
    r.in_valid = iv; r.out_ready = orr; r.valid = v; r.plane = pl;
    r.idx = idx; r.ready = rdy; r.stb = stb; r.done = dn;
    return r;
  endfunction

  function automatic logic [3:0] plane_of(input logic [15:0] v, input int p);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[i*4 + p];
    return r;
  endfunction

  // One cycle of the small instance: drive after the edge, then settle for checks.
  task automatic cyc_a(input logic iv, input logic orr, input logic [15:0] act);
    @(posedge clk);
    #1;
    ia.in_valid  = iv;
    ia.out_ready = orr;
    ia.in_act    = act;
    #2;
  endtask

  task automatic check_a(input string tag, input logic v, input logic [3:0] pl, input int idx,
                         input logic rdy, input logic [2:0] stb, input logic dn);
    check({tag, "_valid"}, ia.out_valid, v);
    if (v) begin
      check({tag, "_plane"}, ia.out_plane, pl);
      check({tag, "_idx"},   ia.plane_idx, idx[1:0]);
      check({tag, "_first"}, ia.plane_first, idx == 0);
      check({tag, "_last"},  ia.plane_last, idx == 3);
    end else begin
      check({tag, "_last"},  ia.plane_last, 1'b0);
    end
    check({tag, "_ready"}, ia.in_ready, rdy);
    check({tag, "_stb"},   {ia.acc_cl_en, ia.acc_w_en, ia.acc_s_en}, stb);
    check({tag, "_done"},  ia.acc_done, dn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t       rows[7];
    logic [15:0] v1, v2, v3;
    int          done_at[$];

    ia.in_valid = 1'b0; ia.out_ready = 1'b0; ia.in_act = '0;
    ib.in_valid = 1'b0; ib.out_ready = 1'b0; ib.in_act = '0;

    // ---- reset values
    #1;
    check("rst_ready", ia.in_ready, 1'b0);
    check("rst_valid", ia.out_valid, 1'b0);
    check("rst_plane", ia.out_plane, 4'h0);
    check("rst_idx",   ia.plane_idx, 2'd0);
    check("rst_flags", {ia.plane_first, ia.plane_last}, 2'b00);
    check("rst_stb",   {ia.acc_cl_en, ia.acc_w_en, ia.acc_s_en}, S_NONE);
    check("rst_done",  ia.acc_done, 1'b0);
    #22 rst_n = 1'b1;

    // ---- single vector, table driven
    rows[0] = mk(1, 1, 0, 4'h0,    0, 1, S_NONE,  0);
    rows[1] = mk(0, 1, 1, 4'b1010, 0, 0, S_LOAD,  0);
    rows[2] = mk(0, 1, 1, 4'b1001, 1, 0, S_SHIFT, 0);
    rows[3] = mk(0, 1, 1, 4'b1010, 2, 0, S_SHIFT, 0);
    rows[4] = mk(0, 1, 1, 4'b1001, 3, 1, S_SHIFT, 0);
    rows[5] = mk(0, 1, 0, 4'h0,    0, 1, S_NONE,  1);
    rows[6] = mk(0, 1, 0, 4'h0,    0, 1, S_NONE,  0);
    for (int r = 0; r < 7; r++) begin
      cyc_a(rows[r].in_valid, rows[r].out_ready, 16'hF05A);
      check_a($sformatf("tbl%0d", r), rows[r].valid, rows[r].plane, rows[r].idx,
              rows[r].ready, rows[r].stb, rows[r].done);
    end

    // ---- stall during plane 1
    cyc_a(1, 1, 16'hF05A);
    cyc_a(0, 1, 16'h0000); check_a("st_b0", 1, 4'b1010, 0, 0, S_LOAD, 0);
    for (int s = 0; s < 3; s++) begin
      cyc_a(0, 0, 16'h0000); check_a($sformatf("st_hold%0d", s), 1, 4'b1001, 1, 0, S_NONE, 0);
    end
    cyc_a(0, 1, 16'h0000); check_a("st_b1", 1, 4'b1001, 1, 0, S_SHIFT, 0);
    cyc_a(0, 1, 16'h0000); check_a("st_b2", 1, 4'b1010, 2, 0, S_SHIFT, 0);
    cyc_a(0, 1, 16'h0000); check_a("st_b3", 1, 4'b1001, 3, 1, S_SHIFT, 0);
    cyc_a(0, 1, 16'h0000); check_a("st_end", 0, 4'h0, 0, 1, S_NONE, 1);

    // ---- back-to-back vectors with in_valid held high
    v1 = 16'h8C3F; v2 = 16'h52E7;
    cyc_a(1, 1, v1);
    for (int b = 0; b < 9; b++) begin
      cyc_a(b < 4, 1, v2);
      if (ia.acc_done) done_at.push_back(b);
      if (b < 8)
        check_a($sformatf("b2b%0d", b), 1, plane_of(b < 4 ? v1 : v2, b % 4), b % 4,
                (b == 3) || (b == 7), (b % 4 == 0) ? S_LOAD : S_SHIFT, b == 4);
      else
        check_a("b2b_end", 0, 4'h0, 0, 1, S_NONE, 1);
    end
    check("b2b_done_cnt", done_at.size(), 2);
    if (done_at.size() == 2) check("b2b_done_gap", done_at[1] - done_at[0], 4);

    // ---- reset during plane 2
    cyc_a(1, 1, 16'hF05A);
    cyc_a(0, 1, 16'h0000);
    cyc_a(0, 1, 16'h0000);
    @(posedge clk); #1;
    check("mr_pre_idx", ia.plane_idx, 2'd2);
    rst_n = 1'b0;
    #1;
    check("mr_valid", ia.out_valid, 1'b0);
    check("mr_ready", ia.in_ready, 1'b0);
    check("mr_plane", ia.out_plane, 4'h0);
    check("mr_idx",   ia.plane_idx, 2'd0);
    check("mr_flags", {ia.plane_first, ia.plane_last}, 2'b00);
    check("mr_stb",   {ia.acc_cl_en, ia.acc_w_en, ia.acc_s_en}, S_NONE);
    check("mr_done",  ia.acc_done, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    v3 = 16'h7E81;
    cyc_a(1, 1, v3); check_a("mr_rel", 0, 4'h0, 0, 1, S_NONE, 0);
    for (int b = 0; b < 4; b++) begin
      cyc_a(0, 1, 16'h0000);
      check_a($sformatf("mr_b%0d", b), 1, plane_of(v3, b), b, b == 3, b == 0 ? S_LOAD : S_SHIFT, 0);
    end
    cyc_a(0, 1, 16'h0000); check_a("mr_end", 0, 4'h0, 0, 1, S_NONE, 1);

    // ---- randomized traffic on the default-size instance
    begin
      logic [127:0] sent[$];
      logic [127:0] front, got;
      logic [15:0]  pl[8];
      logic         xfer;
      int           exp_p, vecs, dones, val;
      xfer = 1'b0; exp_p = 0; vecs = 0; dones = 0;
      for (int c = 0; c < 800; c++) begin
        @(posedge clk);
        #1;
        if (xfer) ib.in_valid = 1'b0;
        if (!ib.in_valid && c < 600 && $urandom_range(0, 3) != 0) begin
          ib.in_valid = 1'b1;
          ib.in_act   = {$urandom, $urandom, $urandom, $urandom};
        end
        ib.out_ready = (c >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
        #2;
        xfer = ib.in_valid & ib.in_ready;
        if (xfer) sent.push_back(ib.in_act);
        if (ib.acc_done) dones++;
        check("rnd_stb", {ib.acc_cl_en, ib.acc_w_en, ib.acc_s_en},
              (ib.out_valid && ib.out_ready) ? ((exp_p == 0) ? S_LOAD : S_SHIFT) : S_NONE);
        if (ib.out_valid && ib.out_ready) begin
          check("rnd_idx", ib.plane_idx, exp_p[2:0]);
          check("rnd_last", ib.plane_last, exp_p == 7);
          pl[exp_p] = ib.out_plane;
          if (exp_p == 7) begin
            for (int i = 0; i < 16; i++) begin
              val = 0;
              for (int p = 0; p < 7; p++) val += int'(pl[p][i]) * (1 << p);
              val -= int'(pl[7][i]) * 128;
              got[i*8 +: 8] = val[7:0];
            end
            if (sent.size() == 0) begin
              check("rnd_underflow", 1'b1, 1'b0);
            end else begin
              front = sent.pop_front();
              check("rnd_vec", got, front);
            end
            vecs++;
            exp_p = 0;
          end else begin
            exp_p++;
          end
        end
      end
      check("rnd_drained", sent.size(), 0);
      check("rnd_partial", exp_p, 0);
      check("rnd_done_cnt", dones, vecs);
      check("rnd_progress", vecs > 20, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
